wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
// - Write-back stage plus general register file: consumes MEM/WB pipeline register outputs
//   (instr, pc, ALU result, DM read data), decodes the destination register and source,
//   writes the GRF, and serves the decode stage's two read ports with same-cycle W->D bypass.
// - Also exports the write-back tuple (we/addr/data) for the hazard/forwarding unit.
// PARAMETERS
// - LINK_REG     31  destination register for jal
// - LINK_OFFSET  8   jal write data = w_pc + LINK_OFFSET
// PORTS
// - clk        in   1   clock, all state updates on posedge
// - reset      in   1   synchronous, active-high
// - w_instr    in   32  instruction in W stage (0 = bubble/nop)
// - w_pc       in   32  PC of W-stage instruction
// - w_alu      in   32  ALU result carried to W
// - w_dm       in   32  data-memory read data carried to W
// - rs_addr    in   5   D-stage read port A address
// - rt_addr    in   5   D-stage read port B address
// - rs_data    out  32  read port A data (combinational)
// - rt_data    out  32  read port B data (combinational)
// - wb_we      out  1   W stage writes a non-zero register this cycle
// - wb_addr    out  5   W-stage destination register (0 when no write)
// - wb_data    out  32  W-stage write data
// BEHAVIOUR
// - Reset: reset, synchronous, active-high; clock clk. On posedge with reset=1 all 32 regs
//   <= 0; no write from W that cycle. While reset=1: wb_we=0, wb_addr=0, bypass disabled.
// - Decode (op=w_instr[31:26], fn=w_instr[5:0]):
//   op 000000 fn 100000 add / 100010 sub -> dest rd[15:11], data w_alu
//   op 001101 ori, 001111 lui           -> dest rt[20:16], data w_alu
//   op 100011 lw                        -> dest rt[20:16], data w_dm
//   op 000011 jal                       -> dest LINK_REG,  data w_pc+LINK_OFFSET (mod 2^32)
//   all else (sw, beq, jr, nop, unknown) -> no write
// - wb_we = decoded write && dest!=0 && !reset; wb_addr = wb_we ? dest : 0;
//   wb_data = selected data when wb_we, else 0.
// - Write: on posedge, if wb_we, reg[wb_addr] <= wb_data. Latency 1 cycle to array.
// - $0: never written, always reads 0 (also via bypass).
// - Read: rs_data = (rs_addr==0) ? 0 : (wb_we && wb_addr==rs_addr) ? wb_data : reg[rs_addr];
//   rt_data identical on rt_addr. Bypass gives same-cycle visibility of W result to D.
// - Both ports may read the same register and may both hit the bypass simultaneously.
// - Reset mid-stream: W instruction present during reset cycle is dropped, not retried.
// - Each committed write emits $display("@%h: $%d <= %h", w_pc, wb_addr, wb_data)
//   (simulation only; format is fixed for grading diff).
// TESTING
// - Reset then read all 32 addrs on both ports -> every rs_data/rt_data = 0.
// - w_instr=ori $8,$0,0x1234 (0x34081234), w_alu=0x1234 -> same cycle rs_addr=8 reads
//   0x1234 via bypass; next cycle with w_instr=0 still reads 0x1234 from array.
// - lw $9 (0x8C090000), w_alu=0xDEAD, w_dm=0x00C0FFEE -> reg9=0x00C0FFEE (dm chosen, not alu).
// - jal (0x0C000C00), w_pc=0x00003010 -> reg31=0x00003018, wb_addr=31, wb_we=1.
// - add writing $0 (rd=0, w_alu=5) -> wb_we=0, reads of $0 stay 0; sw/beq/jr -> no write.
// - Write $10=0x55 while reset=1 -> reg10 stays 0, wb_we=0; rs_addr=rt_addr=10 with
//   active W write of 0xAA -> both ports = 0xAA.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back decode plus 32x32 register file with same-cycle W->D bypass on both read ports.
// Latency: reads are combinational; a write reaches the array one cycle later (bypass covers that cycle).
// Backpressure: none; every W-stage instruction is consumed each cycle, and one in W during reset is dropped.
module wb_regfile #(
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned LINK_OFFSET = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] w_instr,
    input  logic [31:0] w_pc,
    input  logic [31:0] w_alu,
    input  logic [31:0] w_dm,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    localparam logic [4:0]  LINK_ADDR = LINK_REG[4:0];
    localparam logic [31:0] LINK_INC  = 32'(LINK_OFFSET);

    logic [31:0] regs_q [32];

    logic [5:0]  op;
    logic [5:0]  fn;
    logic        dec_wr;
    logic [4:0]  dec_dest;
    logic [31:0] dec_data;

    assign op = w_instr[31:26];
    assign fn = w_instr[5:0];

    always_comb begin
        dec_wr   = 1'b0;
        dec_dest = 5'd0;
        dec_data = 32'd0;
        unique case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB) begin
                    dec_wr   = 1'b1;
                    dec_dest = w_instr[15:11];
                    dec_data = w_alu;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_wr   = 1'b1;
                dec_dest = w_instr[20:16];
                dec_data = w_alu;
            end
            OP_LW: begin
                dec_wr   = 1'b1;
                dec_dest = w_instr[20:16];
                dec_data = w_dm;
            end
            OP_JAL: begin
                dec_wr   = 1'b1;
                dec_dest = LINK_ADDR;
                dec_data = w_pc + LINK_INC;
            end
            default: ;
        endcase
    end

    // Writes to $0 are suppressed here, so the bypass can never forward into $0.
    assign wb_we   = dec_wr && (dec_dest != 5'd0) && !reset;
    assign wb_addr = wb_we ? dec_dest : 5'd0;
    assign wb_data = wb_we ? dec_data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wb_we) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == 5'd0) begin
            rs_data = 32'd0;
        end else if (wb_we && wb_addr == rs_addr) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == 5'd0) begin
            rt_data = 32'd0;
        end else if (wb_we && wb_addr == rt_addr) begin
            rt_data = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: decode, array write, W->D bypass, $0 and reset handling.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_alu;
    logic [31:0] w_dm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total;
    int bad;

    wb_regfile #(.LINK_REG(31), .LINK_OFFSET(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .w_instr (w_instr),
        .w_pc    (w_pc),
        .w_alu   (w_alu),
        .w_dm    (w_dm),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit trace in the fixed grading format.
    always @(posedge clk) begin
        if (wb_we) $display("@%h: $%d <= %h", w_pc, wb_addr, wb_data);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dm);
        w_instr = instr;
        w_pc    = pc;
        w_alu   = alu;
        w_dm    = dm;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rs_addr = a;
        rt_addr = b;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        step();
        step();
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk("rst_rs", rs_data, 32'd0);
            chk("rst_rt", rt_data, 32'd0);
        end

        // ori $8,$0,0x1234
        drive(32'h34081234, 32'h00003000, 32'h00001234, 32'h0);
        rd(5'd8, 5'd0);
        chk("ori_byp", rs_data, 32'h00001234);
        chk("ori_we", {31'd0, wb_we}, 32'd1);
        chk("ori_addr", {27'd0, wb_addr}, 32'd8);
        chk("ori_r0", rt_data, 32'd0);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd8, 5'd8);
        chk("ori_arr_rs", rs_data, 32'h00001234);
        chk("ori_arr_rt", rt_data, 32'h00001234);
        chk("nop_we", {31'd0, wb_we}, 32'd0);
        chk("nop_addr", {27'd0, wb_addr}, 32'd0);
        chk("nop_data", wb_data, 32'd0);

        // lw $9 selects dm
        drive(32'h8C090000, 32'h00003004, 32'h0000DEAD, 32'h00C0FFEE);
        rd(5'd0, 5'd9);
        chk("lw_data", wb_data, 32'h00C0FFEE);
        chk("lw_byp", rt_data, 32'h00C0FFEE);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd9, 5'd8);
        chk("lw_arr", rs_data, 32'h00C0FFEE);
        chk("lw_keep8", rt_data, 32'h00001234);

        // jal -> $31 = pc+8
        drive(32'h0C000C00, 32'h00003010, 32'h11111111, 32'h22222222);
        rd(5'd31, 5'd0);
        chk("jal_we", {31'd0, wb_we}, 32'd1);
        chk("jal_addr", {27'd0, wb_addr}, 32'd31);
        chk("jal_data", wb_data, 32'h00003018);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd31, 5'd31);
        chk("jal_arr", rs_data, 32'h00003018);

        // add with rd=$0
        drive(32'h00000020, 32'h00003014, 32'h00000005, 32'h0);
        rd(5'd0, 5'd0);
        chk("add0_we", {31'd0, wb_we}, 32'd0);
        chk("add0_rs", rs_data, 32'd0);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd0, 5'd0);
        chk("add0_arr", rt_data, 32'd0);

        // add $3, sub $4, lui $5
        drive(32'h00001820, 32'h00003020, 32'h00000007, 32'h0);
        step();
        drive(32'h00002022, 32'h00003024, 32'h00000009, 32'h0);
        rd(5'd4, 5'd3);
        chk("sub_byp", rs_data, 32'h00000009);
        chk("add_arr", rt_data, 32'h00000007);
        step();
        drive(32'h3C05ABCD, 32'h00003028, 32'hABCD0000, 32'h0);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd4, 5'd5);
        chk("sub_arr", rs_data, 32'h00000009);
        chk("lui_arr", rt_data, 32'hABCD0000);

        // sw, beq, jr: no writes even though rt/rd fields name $9
        drive(32'hAD090000, 32'h0000302C, 32'h00000BAD, 32'h00000BAD);
        rd(5'd9, 5'd9);
        chk("sw_we", {31'd0, wb_we}, 32'd0);
        step();
        drive(32'h10090003, 32'h00003030, 32'h00000BAD, 32'h00000BAD);
        rd(5'd9, 5'd9);
        chk("beq_we", {31'd0, wb_we}, 32'd0);
        step();
        drive(32'h03E04808, 32'h00003034, 32'h00000BAD, 32'h00000BAD);
        rd(5'd9, 5'd9);
        chk("jr_we", {31'd0, wb_we}, 32'd0);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd9, 5'd9);
        chk("nowr_arr", rs_data, 32'h00C0FFEE);

        // ori $10,0x55 during reset: dropped, array cleared
        reset = 1'b1;
        drive(32'h340A0055, 32'h00003038, 32'h00000055, 32'h0);
        rd(5'd10, 5'd10);
        chk("rstw_we", {31'd0, wb_we}, 32'd0);
        chk("rstw_addr", {27'd0, wb_addr}, 32'd0);
        chk("rstw_data", wb_data, 32'd0);
        chk("rstw_byp", rs_data, 32'd0);
        step();
        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd10, 5'd8);
        chk("rstw_arr10", rs_data, 32'd0);
        chk("rstw_arr8", rt_data, 32'd0);

        // both ports bypass the same register
        drive(32'h340A00AA, 32'h0000303C, 32'h000000AA, 32'h0);
        rd(5'd10, 5'd10);
        chk("dual_rs", rs_data, 32'h000000AA);
        chk("dual_rt", rt_data, 32'h000000AA);
        step();
        drive(32'h340A0077, 32'h00003040, 32'h00000077, 32'h0);
        rd(5'd10, 5'd10);
        chk("byp_over_arr", rs_data, 32'h00000077);
        step();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        rd(5'd10, 5'd10);
        chk("final_arr", rt_data, 32'h00000077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
